// File: rtl/hilo_pkg.sv
// hilo_pkg: shared width, op encodings and FSM states for the HI/LO unit
package hilo_pkg;
    localparam int WIDTH = 32;
    typedef enum logic [2:0] {
        OP_NONE = 3'b000,
        OP_MULT = 3'b001,
        OP_DIV  = 3'b010,
        OP_DIVU = 3'b011,
        OP_MTHI = 3'b100,
        OP_MTLO = 3'b101
    } op_t;
    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;
endpackage

// File: rtl/hilo_unit_div_core.sv
// div_core: iterative restoring divider on unsigned magnitudes, one quotient bit per step
module div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             last
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    logic [WIDTH-1:0] rem, quo, dsr;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   r_sh, diff;
    logic             ge;
    // the dividend shifts out of quo MSB-first while quotient bits shift in at the bottom
    assign r_sh = {rem, quo[WIDTH-1]};
    assign diff = r_sh - {1'b0, dsr};
    assign ge = r_sh >= {1'b0, dsr};
    assign quotient = quo;
    assign remainder = rem;
    assign last = cnt == LAST;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem <= '0;
            quo <= '0;
            dsr <= '0;
            cnt <= '0;
        end else if (load) begin
            rem <= '0;
            quo <= dividend;
            dsr <= divisor;
            cnt <= '0;
        end else if (step) begin
            rem <= ge ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ge};
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO register file with mult/mthi/mtlo writes and a 33-cycle iterative divide
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH = hilo_pkg::WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   busA,
    input  logic [WIDTH-1:0]   busB,
    input  logic [2*WIDTH-1:0] mult_Result,
    input  logic               flush,
    output logic               busy,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);
    state_t state, next;
    op_t opc;
    logic accept, go_div, is_signed, last, done_wr, neg_q, neg_r, b_zero;
    logic [WIDTH-1:0] a_raw, mag_a, mag_b, quo, rem, q_fix, r_fix;
    assign opc = op_t'(op);
    assign accept = start && !flush && state == S_IDLE;
    assign go_div = accept && (opc == OP_DIV || opc == OP_DIVU);
    assign is_signed = opc == OP_DIV;
    assign mag_a = (is_signed && busA[WIDTH-1]) ? -busA : busA;
    assign mag_b = (is_signed && busB[WIDTH-1]) ? -busB : busB;
    assign busy = state != S_IDLE;
    assign done_wr = state == S_DONE && !flush;
    assign q_fix = neg_q ? -quo : quo;
    assign r_fix = neg_r ? -rem : rem;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else state <= next;
    end
    always_comb begin
        next = state;
        next = flush ? S_IDLE :
               state == S_IDLE ? (go_div ? S_DIV : S_IDLE) :
               state == S_DIV ? (last ? S_DONE : S_DIV) : S_IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_raw  <= '0;
            b_zero <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else if (go_div) begin
            a_raw  <= busA;
            b_zero <= busB == '0;
            neg_q  <= is_signed && (busA[WIDTH-1] ^ busB[WIDTH-1]);
            neg_r  <= is_signed && busA[WIDTH-1];
        end
    end
    div_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (go_div),
        .step      (state == S_DIV),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (quo),
        .remainder (rem),
        .last      (last)
    );
    // divide-by-zero reports the raw dividend, bypassing the sign fix-up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (accept && opc == OP_MULT) begin
            hi <= mult_Result[2*WIDTH-1:WIDTH];
            lo <= mult_Result[WIDTH-1:0];
        end else if (accept && opc == OP_MTHI) begin
            hi <= busA;
        end else if (accept && opc == OP_MTLO) begin
            lo <= busA;
        end else if (done_wr) begin
            hi <= b_zero ? a_raw : r_fix;
            lo <= b_zero ? '1 : q_fix;
        end
    end
endmodule
